// File: rtl/grasspopper_out_buf_if.sv
// Block-in / byte-out bus of the Grasspopper output buffer.
// The master side is the encoder plus the byte consumer; the slave side is the buffer itself.
interface grasspopper_out_buf_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [127:0]     data_i;
  logic             valid_i;
  logic [7:0]       byte_o;
  logic             byte_valid_o;
  logic             byte_ready_i;
  logic             last_o;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             overflow_o;

  modport slave (
    input  data_i, valid_i, byte_ready_i,
    output byte_o, byte_valid_o, last_o, count_o, full_o, overflow_o
  );

  modport master (
    output data_i, valid_i, byte_ready_i,
    input  byte_o, byte_valid_o, last_o, count_o, full_o, overflow_o
  );
endinterface

// File: rtl/grasspopper_out_buf.sv
// Grasspopper output buffer: captures 128-bit ciphertext blocks from a pipeline
// with no backpressure into a DEPTH-slot FIFO, then serialises each block into
// 16 bytes over a valid/ready byte stream.
// Optional build macro GRASS_OBUF_MSB_FIRST_EN: bytes leave most-significant first
// (default is least-significant first).
module grasspopper_out_buf #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  grasspopper_out_buf_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [127:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_full;
  logic             r_overflow;

  logic [127:0]     r_shift;
  logic [3:0]       r_idx;

  logic             w_hs;
  logic             w_pop;
  logic             w_shift;
  logic             w_wr;
  logic             w_nonempty;

  assign w_nonempty = (r_count != '0);
  assign w_hs       = (r_state == S_SEND) && bus.byte_ready_i;

  // A slot frees up on the same edge as a pop, so a full FIFO still accepts then.
  assign w_wr = bus.valid_i && ((r_count != DEPTH_C) || w_pop);

  // Serialiser next-state: load from the FIFO head, step bytes, chain blocks without a bubble.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_pop        = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (r_idx != 4'd15) begin
            w_shift = 1'b1;
          end else if (w_nonempty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Serialiser state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Occupancy update: simultaneous write and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_pop)      w_count_next = r_count + CNT_W'(1);
    else if (!w_wr && w_pop) w_count_next = r_count - CNT_W'(1);
  end

  // Block storage; no reset so it maps onto RAM, the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.data_i;
  end

  // FIFO pointers, occupancy, full flag and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      if (bus.valid_i && !w_wr) r_overflow <= 1'b1;
    end
  end

  // Shift register and byte index; the shift register doubles as the RAM read register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_idx   <= '0;
    end else if (w_shift) begin
`ifdef GRASS_OBUF_MSB_FIRST_EN
      r_shift <= {r_shift[119:0], 8'h00};
`else
      r_shift <= {8'h00, r_shift[127:8]};
`endif
      r_idx   <= r_idx + 4'd1;
    end
  end

`ifdef GRASS_OBUF_MSB_FIRST_EN
  assign bus.byte_o = r_shift[127:120];
`else
  assign bus.byte_o = r_shift[7:0];
`endif
  assign bus.byte_valid_o = (r_state == S_SEND);
  assign bus.last_o       = (r_state == S_SEND) && (r_idx == 4'd15);
  assign bus.count_o      = r_count;
  assign bus.full_o       = r_full;
  assign bus.overflow_o   = r_overflow;

endmodule
